// File: rtl/pipe_stage_fifo.sv
// Handshake pipeline stage: transforms each captured word and buffers up to DEPTH results.
// Define PIPE_STAGE_FIFO_LEVEL_EN to expose the registered occupancy on the level port.
module pipe_stage_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OP    = 0,
    parameter int K     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    DIR,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    ack_prev,
    output logic                    DOR,
    output logic [WIDTH-1:0]        data_out,
    input  logic                    ack_from_next
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] K_W        = WIDTH'(K);
    localparam logic [PW:0]      FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // ack_prev blocks a second capture while upstream is still dropping DIR.
    assign push = DIR && !full && !ack_prev;
    assign pop  = DOR && ack_from_next;

    assign data_out = mem[rd_ptr];

    always_comb begin
        result = data_in;
        if (OP == 0) begin
            result = data_in + K_W;
        end else if (OP == 1) begin
            result = data_in - K_W;
        end
    end

    // DOR follows the pre-update occupancy, giving one cycle between capture and
    // presentation, and returns to zero for the cycle after every pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ack_prev <= 1'b0;
            DOR      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            ack_prev <= push;
            DOR      <= !empty && !pop;
        end
    end

`ifdef PIPE_STAGE_FIFO_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench for pipe_stage_fifo: three lanes (OP 0, 1, 2; K=1; DEPTH=4).
// Level checks are compiled in only when PIPE_STAGE_FIFO_LEVEL_EN is defined.
module tb_pipe_stage_fifo;

    logic       clk;
    logic       reset;
    logic [2:0] dir;
    logic [7:0] din [3];
    logic [2:0] ackp;
    logic [2:0] dor;
    logic [7:0] dout [3];
    logic [2:0] ackn;
    logic [2:0] ack_en;
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
    logic [2:0] lvl [3];
`endif

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    int checks;
    int errors;
    int ackp_cnt [3];

    for (genvar g = 0; g < 3; g++) begin : g_lane
        pipe_stage_fifo #(.WIDTH(8), .DEPTH(4), .OP(g), .K(1)) u_dut (
            .clk(clk),
            .reset(reset),
            .DIR(dir[g]),
            .data_in(din[g]),
            .ack_prev(ackp[g]),
            .DOR(dor[g]),
            .data_out(dout[g]),
            .ack_from_next(ackn[g])
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
            ,
            .level(lvl[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int qsize(input int lane);
        case (lane)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Raise DIR with a word and queue its hand-computed transformed value.
    task automatic offerWord(input int lane, input logic [7:0] value, input logic [7:0] expected);
        dir[lane] = 1'b1;
        din[lane] = value;
        case (lane)
            0:       q0.push_back(expected);
            1:       q1.push_back(expected);
            default: q2.push_back(expected);
        endcase
    endtask

    task automatic waitCapture(input int lane);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ackp[lane]) got = 1'b1;
        end
        dir[lane] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL capture_timeout lane %0d: got no ack_prev, expected one", lane);
        end
    endtask

    task automatic applyStimulus(input int lane, input logic [7:0] value, input logic [7:0] expected);
        offerWord(lane, value, expected);
        waitCapture(lane);
    endtask

    task automatic waitDrain(input int lane);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (qsize(lane) == 0 && !dor[lane]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout lane %0d: got %0d words pending, expected 0", lane, qsize(lane));
        end
    endtask

    // Peer-style downstream responder: one-cycle ack whenever DOR is seen high.
    initial begin
        ackn = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                ackn[i] = ack_en[i] && dor[i] && !ackn[i];
            end
        end
    end

    // Monitor: every pop is compared against the scoreboard head; ack_prev must be
    // a single-cycle pulse and DOR must be low in the cycle after a pop.
    initial begin
        bit         prev_pop  [3];
        bit         prev_ackp [3];
        logic [7:0] exp_word;
        for (int i = 0; i < 3; i++) begin
            prev_pop[i]  = 1'b0;
            prev_ackp[i] = 1'b0;
            ackp_cnt[i]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    if (prev_pop[i]) checkOutput($sformatf("dor_rtz_lane%0d", i), int'(dor[i]), 0);
                    if (ackp[i]) begin
                        ackp_cnt[i]++;
                        checkOutput($sformatf("ack_prev_pulse_lane%0d", i), int'(prev_ackp[i]), 0);
                    end
                    if (dor[i] && ackn[i]) begin
                        if (qsize(i) == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_word lane %0d: got %0d, expected no output", i, dout[i]);
                        end else begin
                            case (i)
                                0:       exp_word = q0.pop_front();
                                1:       exp_word = q1.pop_front();
                                default: exp_word = q2.pop_front();
                            endcase
                            checkOutput($sformatf("data_out_lane%0d", i), int'(dout[i]), int'(exp_word));
                        end
                    end
                end
                prev_pop[i]  = dor[i] && ackn[i] && !reset;
                prev_ackp[i] = ackp[i];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        dir    = '0;
        ack_en = '0;
        for (int i = 0; i < 3; i++) din[i] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: all outputs stay zero.
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("idle_dor_lane%0d", i), int'(dor[i]), 0);
                checkOutput($sformatf("idle_ack_prev_lane%0d", i), int'(ackp[i]), 0);
                checkOutput($sformatf("idle_data_out_lane%0d", i), int'(dout[i]), 0);
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
                checkOutput($sformatf("idle_level_lane%0d", i), int'(lvl[i]), 0);
`endif
            end
        end

        // Single word through a peer-style responder.
        ack_en[0] = 1'b1;
        applyStimulus(0, 8'd10, 8'd11);
        waitDrain(0);
        checkOutput("single_ack_prev_count", ackp_cnt[0], 1);

        // Fill with no downstream acks; word 5 must wait for a free entry.
        ack_en[0] = 1'b0;
        base = ackp_cnt[0];
        applyStimulus(0, 8'd1, 8'd2);
        applyStimulus(0, 8'd2, 8'd3);
        applyStimulus(0, 8'd3, 8'd4);
        applyStimulus(0, 8'd4, 8'd5);
        offerWord(0, 8'd5, 8'd6);
        repeat (6) @(negedge clk);
        checkOutput("full_ack_prev_count", ackp_cnt[0] - base, 4);
        checkOutput("full_dor", int'(dor[0]), 1);
        checkOutput("full_head", int'(dout[0]), 2);
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
        checkOutput("full_level", int'(lvl[0]), 4);
`endif
        ack_en[0] = 1'b1;
        waitCapture(0);
        checkOutput("full_release_count", ackp_cnt[0] - base, 5);
        waitDrain(0);

        // Wrap-around and pass-through boundaries on each lane.
        ack_en = 3'b111;
        applyStimulus(0, 8'd255, 8'd0);
        applyStimulus(1, 8'd0, 8'd255);
        applyStimulus(2, 8'hA5, 8'hA5);
        waitDrain(0);
        waitDrain(1);
        waitDrain(2);

        // Push and pop on the same edge with two words stored.
        ack_en[0] = 1'b0;
        applyStimulus(0, 8'd20, 8'd21);
        applyStimulus(0, 8'd21, 8'd22);
        repeat (2) @(negedge clk);
        checkOutput("simul_dor_before", int'(dor[0]), 1);
        ack_en[0] = 1'b1;
        @(negedge clk);
        offerWord(0, 8'd22, 8'd23);
        @(negedge clk);
        checkOutput("simul_push_ack", int'(ackp[0]), 1);
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
        checkOutput("simul_level", int'(lvl[0]), 2);
`endif
        dir[0] = 1'b0;
        waitDrain(0);

        // Reset with three words stored and DOR high, then a fresh word.
        ack_en[0] = 1'b0;
        applyStimulus(0, 8'd30, 8'd31);
        applyStimulus(0, 8'd31, 8'd32);
        applyStimulus(0, 8'd32, 8'd33);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_dor", int'(dor[0]), 1);
        checkOutput("pre_reset_head", int'(dout[0]), 31);
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
        checkOutput("pre_reset_level", int'(lvl[0]), 3);
`endif
        reset = 1'b1;
        q0.delete();
        @(negedge clk);
        checkOutput("post_reset_dor", int'(dor[0]), 0);
        checkOutput("post_reset_data_out", int'(dout[0]), 0);
        checkOutput("post_reset_ack_prev", int'(ackp[0]), 0);
`ifdef PIPE_STAGE_FIFO_LEVEL_EN
        checkOutput("post_reset_level", int'(lvl[0]), 0);
`endif
        reset = 1'b0;
        ack_en[0] = 1'b1;
        applyStimulus(0, 8'd7, 8'd8);
        waitDrain(0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
